kernel_stream_tx: RTL and testbench
===================================

// Module: kernel_stream_tx
// PURPOSE
//  Transmitter end of the kernel stream: feeds the str_ker valid/ready port of the kernel buffer.
//  Takes narrow kernel words from the host-side source FIFO and packs RATIO of them into one
//  OUT_WIDTH beat. Sends a configured number of beats per job.
//  Started by a cfg-bus write. Sits between the host DMA/FIFO and the kernel buffer.
// PARAMETERS
//  CFG_DWIDTH   32  cfg bus data width
//  CFG_AWIDTH   5   cfg bus address width
//  CFG_KER_TX   8   cfg address that loads the beat count and starts a job
//  SRC_WIDTH    16  source word width
//  GROUP_NB     4   kernel groups per beat
//  KER_WIDTH    16  bits per kernel element
//  DEPTH_NB     1   depth elements per group
//  MEM_AWIDTH   8   beat counter width
//  (derived) OUT_WIDTH = GROUP_NB*KER_WIDTH*DEPTH_NB; RATIO = OUT_WIDTH/SRC_WIDTH (integer >=1, must divide exactly)
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous reset, active-low (0 = reset)
//  cfg_data     in   CFG_DWIDTH  cfg write data
//  cfg_addr     in   CFG_AWIDTH  cfg write address
//  cfg_valid    in   1           cfg write strobe
//  src_data     in   SRC_WIDTH   source kernel word
//  src_val      in   1           source word valid
//  src_rdy      out  1           block accepts source word
//  str_ker      out  OUT_WIDTH   packed kernel beat to kernel buffer
//  str_ker_val  out  1           beat valid
//  str_ker_rdy  in   1           kernel buffer accepts beat
//  busy         out  1           job in progress (state != IDLE)
//  done         out  1           one-cycle pulse after final beat handshake
// BEHAVIOUR
//  Reset (rst==0 at an edge): state IDLE; counters 0. Outputs src_rdy, str_ker_val, busy and done are 0. str_ker = 0.
//   Reset mid-job abandons the job; any partial beat is discarded; no done pulse.
//  Handshakes: src xfer = src_val & src_rdy. Beat xfer = str_ker_val & str_ker_rdy.
//   While str_ker_val=1, str_ker and str_ker_val hold until the beat xfer.
//  FSM IDLE -> PACK -> SEND -> (PACK | IDLE):
//   IDLE: src_rdy=0, str_ker_val=0. On a cfg write with cfg_valid & cfg_addr==CFG_KER_TX:
//    beat_end <= cfg_data[MEM_AWIDTH-1:0]; beat_cnt <= 0; word_cnt <= 0; go to PACK.
//    Beats per job = beat_end+1; 0 means one beat and 2^MEM_AWIDTH-1 means 2^MEM_AWIDTH beats.
//   PACK: src_rdy=1. Each src xfer writes src_data into slice word_cnt of the pack register;
//    word 0 goes to the LSBs. Then word_cnt++.
//    On the xfer with word_cnt==RATIO-1: str_ker <= completed pack; word_cnt <= 0; go to SEND.
//    str_ker_val is 1 on the next cycle, so latency is 1 clk from the last word to the beat.
//   SEND: src_rdy=0, str_ker_val=1. On a beat xfer:
//    if beat_cnt==beat_end: go to IDLE and pulse done=1 for exactly one cycle (the cycle after the xfer);
//    otherwise beat_cnt++ and go to PACK.
//  cfg writes to CFG_KER_TX while busy=1 are ignored. Writes to other addresses are always ignored.
//  A cfg write in the same cycle as the final beat xfer is ignored, because the state is still SEND.
//   A write in the cycle where done=1 is accepted (the state is IDLE).
//  Counters never wrap within a job. word_cnt is $clog2(RATIO) bits wide, or 1 bit when RATIO==1.
//   With RATIO==1, PACK holds for one xfer per beat.
//  busy = (state != IDLE). The source is never read outside PACK, so no words are lost across beats.
// TESTING
//  1 Reset: hold rst=0 6 clks with src_val=1 and str_ker_rdy=1.
//    -> src_rdy, str_ker_val, busy and done are 0 every cycle; str_ker == 0.
//  2 Basic job: cfg write addr 8, data 7; src words 16'h0000..16'h001F back-to-back; str_ker_rdy=1.
//    -> 8 beats; beat0 = 64'h0003_0002_0001_0000; beat7 = 64'h001F_001E_001D_001C.
//    -> done pulses once; busy then falls.
//  3 Backpressure: cfg data 1; str_ker_rdy=0 for 5 clks after beat0 goes valid.
//    -> str_ker and val are stable all 5 clks; src_rdy=0 meanwhile; beat1 follows after release.
//  4 Source gaps: src_val toggles 1/0 each clk for a 1-beat job (cfg data 0).
//    -> only words with src_val=1 are packed; val rises 1 clk after the 4th accepted word.
//  5 Cfg while busy: mid-job write addr 8 data 3, plus a write to addr 2.
//    -> both ignored; the original beat count is completed.
//    -> a write during the done cycle starts a new job.
//  6 Reset mid-job: drive rst=0 after 2 of 4 words of beat1.
//    -> outputs clear; a new job then packs from word 0 with no stale data.

Source files
------------

// File: rtl/kernel_stream_tx.sv
// Kernel stream transmitter: packs RATIO narrow source words into one wide beat
// and sends a cfg-programmed number of beats to the kernel buffer per job.
module kernel_stream_tx #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int CFG_KER_TX = 8,
    parameter int SRC_WIDTH  = 16,
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 1,
    parameter int MEM_AWIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [CFG_DWIDTH-1:0]                   cfg_data,
    input  logic [CFG_AWIDTH-1:0]                   cfg_addr,
    input  logic                                    cfg_valid,
    input  logic [SRC_WIDTH-1:0]                    src_data,
    input  logic                                    src_val,
    output logic                                    src_rdy,
    output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0]  str_ker,
    output logic                                    str_ker_val,
    input  logic                                    str_ker_rdy,
    output logic                                    busy,
    output logic                                    done
);

    localparam int OUT_WIDTH = GROUP_NB * KER_WIDTH * DEPTH_NB;
    localparam int RATIO     = OUT_WIDTH / SRC_WIDTH;
    localparam int WCW       = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PACK = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [WCW-1:0] WORD_LAST = WCW'(RATIO - 1);

    logic [1:0]            state_q, state_d;
    logic [MEM_AWIDTH-1:0] beat_end_q, beat_end_d;
    logic [MEM_AWIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic [OUT_WIDTH-1:0]  pack_q, pack_d;
    logic [OUT_WIDTH-1:0]  str_ker_q, str_ker_d;
    logic                  done_q, done_d;

    logic                  cfg_hit;
    logic                  src_xfer;
    logic                  beat_xfer;
    logic [OUT_WIDTH-1:0]  pack_wr;
    logic                  unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data[CFG_DWIDTH-1:MEM_AWIDTH];

    assign cfg_hit   = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_TX));
    assign src_xfer  = (state_q == ST_PACK) && src_val;
    assign beat_xfer = (state_q == ST_SEND) && str_ker_rdy;

    // Pack register with the current source word merged into slot word_cnt (slot 0 = LSBs).
    always_comb begin
        pack_wr = pack_q;
        for (int i = 0; i < RATIO; i++) begin
            if (word_cnt_q == WCW'(i)) begin
                pack_wr[i*SRC_WIDTH +: SRC_WIDTH] = src_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_end_d = beat_end_q;
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        str_ker_d  = str_ker_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_hit) begin
                    beat_end_d = cfg_data[MEM_AWIDTH-1:0];
                    beat_cnt_d = '0;
                    word_cnt_d = '0;
                    state_d    = ST_PACK;
                end
            end
            ST_PACK: begin
                if (src_xfer) begin
                    pack_d = pack_wr;
                    if (word_cnt_q == WORD_LAST) begin
                        str_ker_d  = pack_wr;
                        word_cnt_d = '0;
                        state_d    = ST_SEND;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // Beat is held until accepted; the final beat ends the job.
                if (beat_xfer) begin
                    if (beat_cnt_q == beat_end_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        state_d    = ST_PACK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_end_q <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            str_ker_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_end_q <= beat_end_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            str_ker_q  <= str_ker_d;
            done_q     <= done_d;
        end
    end

    assign src_rdy     = (state_q == ST_PACK);
    assign str_ker_val = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign str_ker     = str_ker_q;

endmodule

// File: tb/tb_kernel_stream_tx.sv
// Bench for kernel_stream_tx: source words and expected beats are queued together,
// a beat monitor pops and compares on every beat handshake.
module tb_kernel_stream_tx;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic [15:0] src_data;
    logic        src_val;
    logic        src_rdy;
    logic [63:0] str_ker;
    logic        str_ker_val;
    logic        str_ker_rdy;
    logic        busy;
    logic        done;

    kernel_stream_tx dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_data    (cfg_data),
        .cfg_addr    (cfg_addr),
        .cfg_valid   (cfg_valid),
        .src_data    (src_data),
        .src_val     (src_val),
        .src_rdy     (src_rdy),
        .str_ker     (str_ker),
        .str_ker_val (str_ker_val),
        .str_ker_rdy (str_ker_rdy),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [15:0] src_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_total = 0;
    int          done_cnt  = 0;
    bit          gap_en    = 1'b0;
    bit          gap_phase = 1'b0;

    // Beat monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b1 && str_ker_val === 1'b1 && str_ker_rdy === 1'b1) begin
            n_checks++;
            obs_q.push_back(str_ker);
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got %h, expected no beat", str_ker);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (str_ker !== e) $display("FAIL beat_data: got %h, expected %h", str_ker, e);
                else n_pass++;
            end
        end
    end

    task automatic src_refresh();
        if (src_q.size() > 0 && (!gap_en || gap_phase)) begin
            src_val  = 1'b1;
            src_data = src_q[0];
        end else begin
            src_val  = 1'b0;
            src_data = 16'hDEAD;
        end
    endtask

    task automatic cycle();
        bit acc;
        @(negedge clk);
        acc = (src_val === 1'b1) && (src_rdy === 1'b1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        if (acc) begin
            void'(src_q.pop_front());
            acc_total++;
        end
        if (done === 1'b1) done_cnt++;
        gap_phase = !gap_phase;
        src_refresh();
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_valid = 1'b1;
        cycle();
    endtask

    task automatic push_job(input logic [15:0] base, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            logic [63:0] beat;
            beat = '0;
            for (int w = 0; w < 4; w++) begin
                logic [15:0] word;
                word = base + 16'(b * 4 + w);
                src_q.push_back(word);
                beat[w*16 +: 16] = word;
            end
            exp_q.push_back(beat);
        end
    endtask

    task automatic run_until_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            cycle();
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        src_val = 1'b1;
        src_data = 16'h1234;
        str_ker_rdy = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({src_rdy, str_ker_val, busy, done} !== 4'b0 || str_ker !== 64'h0)
                $display("FAIL reset_outputs: cycle %0d got rdy/val/busy/done=%b str_ker=%h, expected 0000 and 0",
                         i, {src_rdy, str_ker_val, busy, done}, str_ker);
            else n_pass++;
        end
        rst = 1'b1;
        src_refresh();
        cycle();
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        int b0;
        d0 = done_cnt;
        b0 = obs_q.size();
        push_job(16'h0000, 8);
        cfg_write(5'd8, 32'd7);
        run_until_done(300, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_timeout: no done within 300 cycles, expected done");
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy: busy=%b in done cycle, expected 0", busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() - b0 != 8) $display("FAIL basic_beats: got %0d beats, expected 8", obs_q.size() - b0);
        else n_pass++;
        n_checks++;
        if (obs_q[b0] !== 64'h0003_0002_0001_0000)
            $display("FAIL basic_beat0: got %h, expected 0003000200010000", obs_q[b0]);
        else n_pass++;
        n_checks++;
        if (obs_q[b0 + 7] !== 64'h001F_001E_001D_001C)
            $display("FAIL basic_beat7: got %h, expected 001f001e001d001c", obs_q[b0 + 7]);
        else n_pass++;
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL basic_done_once: got %0d pulses, expected 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [63:0] held;
        str_ker_rdy = 1'b0;
        push_job(16'h0100, 2);
        cfg_write(5'd8, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            if (str_ker_val === 1'b1) ok = 1'b1;
        end
        n_checks++;
        if (!ok) $display("FAIL bp_val_timeout: str_ker_val never rose, expected 1");
        else n_pass++;
        held = str_ker;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (str_ker !== held || str_ker_val !== 1'b1 || src_rdy !== 1'b0)
                $display("FAIL bp_hold: cycle %0d got str_ker=%h val=%b src_rdy=%b, expected %h 1 0",
                         i, str_ker, str_ker_val, src_rdy, held);
            else n_pass++;
        end
        str_ker_rdy = 1'b1;
        run_until_done(100, ok);
        n_checks++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL bp_complete: done=%b pending=%0d, expected done and 0 pending", ok, exp_q.size());
        else n_pass++;
        cycle();
    endtask

    task automatic test_src_gaps();
        bit ok;
        int a0;
        gap_en = 1'b1;
        a0 = acc_total;
        push_job(16'h0A00, 1);
        cfg_write(5'd8, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            if (acc_total - a0 >= 4) ok = 1'b1;
            else begin
                n_checks++;
                if (str_ker_val !== 1'b0) $display("FAIL gap_early_val: val=%b after %0d words, expected 0",
                                                   str_ker_val, acc_total - a0);
                else n_pass++;
            end
        end
        n_checks++;
        if (!ok || str_ker_val !== 1'b1)
            $display("FAIL gap_latency: val=%b 1 clk after 4th word, expected 1", str_ker_val);
        else n_pass++;
        run_until_done(50, ok);
        n_checks++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL gap_complete: done=%b pending=%0d, expected done and 0 pending", ok, exp_q.size());
        else n_pass++;
        gap_en = 1'b0;
        cycle();
    endtask

    task automatic test_cfg_busy();
        bit ok;
        int d0;
        int b0;
        d0 = done_cnt;
        b0 = obs_q.size();
        push_job(16'h0200, 3);
        cfg_write(5'd8, 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        cfg_write(5'd8, 32'd3);
        cfg_write(5'd2, 32'd5);
        run_until_done(100, ok);
        n_checks++;
        if (!ok || obs_q.size() - b0 != 2 || src_q.size() != 4)
            $display("FAIL busy_cfg_ignored: done=%b beats=%0d words_left=%0d, expected 1 2 4",
                     ok, obs_q.size() - b0, src_q.size());
        else n_pass++;
        cfg_write(5'd8, 32'd0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL done_cycle_cfg: busy=%b, expected 1", busy);
        else n_pass++;
        run_until_done(100, ok);
        n_checks++;
        if (!ok || exp_q.size() != 0 || done_cnt - d0 != 2)
            $display("FAIL done_cycle_job: done=%b pending=%0d pulses=%0d, expected 1 0 2",
                     ok, exp_q.size(), done_cnt - d0);
        else n_pass++;
        cycle();
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int a0;
        int d0;
        a0 = acc_total;
        push_job(16'h0300, 1);
        src_q.push_back(16'h0304);
        src_q.push_back(16'h0305);
        cfg_write(5'd8, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            cycle();
            if (acc_total - a0 >= 6) ok = 1'b1;
        end
        n_checks++;
        if (!ok) $display("FAIL midrst_words: accepted %0d words, expected 6", acc_total - a0);
        else n_pass++;
        rst = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if ({src_rdy, str_ker_val, busy, done} !== 4'b0 || str_ker !== 64'h0)
                $display("FAIL midrst_clear: got rdy/val/busy/done=%b str_ker=%h, expected 0000 and 0",
                         {src_rdy, str_ker_val, busy, done}, str_ker);
            else n_pass++;
        end
        rst = 1'b1;
        src_q.delete();
        push_job(16'h0400, 1);
        cfg_write(5'd8, 32'd0);
        run_until_done(60, ok);
        n_checks++;
        if (!ok || exp_q.size() != 0 || obs_q[obs_q.size() - 1] !== 64'h0403_0402_0401_0400 || done_cnt - d0 != 1)
            $display("FAIL midrst_newjob: done=%b pending=%0d last=%h pulses=%0d, expected 1 0 0403040204010400 1",
                     ok, exp_q.size(), obs_q[obs_q.size() - 1], done_cnt - d0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_src_gaps();
        test_cfg_busy();
        test_reset_mid_job();
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL final_queue: %0d beats pending, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
